// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed RAM plus an MMIO page holding GPIO,
// a cycle counter and a TX FIFO drained over valid/ready. Reads are combinational.
module data_mem_responder #(
    parameter int             N          = 32,
    parameter int             DEPTH      = 1024,
    parameter logic [N-1:0]   MMIO_BASE  = 32'hFFFF_FF00,
    parameter int             FIFO_DEPTH = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] addr_i,
    input  logic [N-1:0] wdata_i,
    input  logic         we_i,
    output logic [N-1:0] rdata_o,
    output logic [N-1:0] gpio_o,
    output logic         tx_valid_o,
    output logic [N-1:0] tx_data_o,
    input  logic         tx_ready_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [7:0] OFF_GPIO   = 8'h00;
    localparam logic [7:0] OFF_CYCLES = 8'h01;
    localparam logic [7:0] OFF_TXDATA = 8'h02;
    localparam logic [7:0] OFF_STATUS = 8'h03;

    logic [N-1:0]  mem [DEPTH];
    logic [N-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [N-1:0]  cycles;

    logic          in_ram, in_io;
    logic [7:0]    offset;
    logic          ram_we, io_we;
    logic          empty, full, pop, push_req, push, overflow_evt;
    logic [N-1:0]  status_word;

    assign in_ram = addr_i < N'(DEPTH);
    assign in_io  = addr_i[N-1:8] == MMIO_BASE[N-1:8];
    assign offset = addr_i[7:0];

    // Writes presented while RST is high must not touch any state.
    assign ram_we = we_i && !RST && in_ram;
    assign io_we  = we_i && !RST && in_io;

    assign empty        = count == '0;
    assign full         = count == CW'(FIFO_DEPTH);
    assign pop          = !empty && tx_ready_i;
    assign push_req     = io_we && offset == OFF_TXDATA;
    assign push         = push_req && (!full || pop);
    assign overflow_evt = push_req && full && !pop;

    assign tx_valid_o = !empty;
    assign tx_data_o  = fifo_mem[rd_ptr];

    // NOTE: RAM and FIFO storage carry no reset so they map onto plain memory;
    // only the control state (pointers, count, flags) is cleared.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            mem[addr_i[AW-1:0]] <= wdata_i;
        end
        if (push) begin
            fifo_mem[wr_ptr] <= wdata_i;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            gpio_o   <= '0;
            cycles   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (io_we && offset == OFF_GPIO) begin
                gpio_o <= wdata_i;
            end

            if (io_we && offset == OFF_CYCLES) begin
                cycles <= '0;
            end else begin
                cycles <= cycles + N'(1);
            end

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end

            // A new overflow in the same cycle as a software clear wins.
            if (overflow_evt) begin
                overflow <= 1'b1;
            end else if (io_we && offset == OFF_STATUS && wdata_i[2]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        status_word      = '0;
        status_word[0]   = empty;
        status_word[1]   = full;
        status_word[2]   = overflow;
        status_word[7:4] = 4'(count);
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        rdata_o = '0;
        if (in_ram) begin
            rdata_o = mem[addr_i[AW-1:0]];
        end else if (in_io) begin
            case (offset)
                OFF_GPIO:   rdata_o = gpio_o;
                OFF_CYCLES: rdata_o = cycles;
                OFF_STATUS: rdata_o = status_word;
                default:    rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed stimulus with a
// scoreboard queue modelling the TX FIFO contents seen by the sink.
module tb_data_mem_responder;

    localparam logic [31:0] MMIO = 32'hFFFF_FF00;
    localparam int          DEPTH = 1024;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic        we_i = 1'b0;
    logic [31:0] rdata_o, gpio_o, tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;

    // Narrow instance so the cycle counter wraps within a short run.
    logic [11:0] addr2 = '0, wdata2 = '0;
    logic        we2 = 1'b0;
    logic [11:0] rdata2, gpio2, tx_data2;
    logic        tx_valid2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb_q[$];

    always #5 CLK = ~CLK;

    data_mem_responder dut (
        .CLK(CLK), .RST(RST), .addr_i(addr_i), .wdata_i(wdata_i), .we_i(we_i),
        .rdata_o(rdata_o), .gpio_o(gpio_o), .tx_valid_o(tx_valid_o),
        .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i)
    );

    data_mem_responder #(.N(12), .DEPTH(16), .MMIO_BASE(12'hF00), .FIFO_DEPTH(2)) dut2 (
        .CLK(CLK), .RST(RST), .addr_i(addr2), .wdata_i(wdata2), .we_i(we2),
        .rdata_o(rdata2), .gpio_o(gpio2), .tx_valid_o(tx_valid2),
        .tx_data_o(tx_data2), .tx_ready_i(1'b0)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // One clock with inputs as currently driven; the FIFO model and sink
    // scoreboard are updated for the edge about to occur.
    task automatic cycle();
        logic [31:0] exp_head;
        bit          pop_m, push_req_m;
        #1;
        if (RST) begin
            sb_q.delete();
        end else begin
            check("tx_valid", {31'b0, tx_valid_o}, {31'b0, sb_q.size() != 0});
            pop_m      = (sb_q.size() != 0) && tx_ready_i;
            push_req_m = we_i && (addr_i == MMIO + 32'h2);
            if (pop_m) begin
                exp_head = sb_q.pop_front();
                check("sink_data", tx_data_o, exp_head);
            end
            if (push_req_m && (sb_q.size() < 8)) begin
                sb_q.push_back(wdata_i);
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr_i = a; wdata_i = d; we_i = 1'b1;
        cycle();
        we_i = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr_i = a; we_i = 1'b0;
        #1;
        check(tag, rdata_o, exp);
    endtask

    task automatic step2();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        @(negedge CLK);
        cycle();
        cycle();
        RST = 1'b0;

        // First cycle after reset
        check("rst_gpio", gpio_o, 32'h0);
        check("rst_valid", {31'b0, tx_valid_o}, 32'h0);
        rd(MMIO + 32'h3, 32'h1, "rst_status");
        rd(MMIO + 32'h1, 32'd0, "cycles_c1");
        for (int i = 0; i < 9; i++) cycle();
        rd(MMIO + 32'h1, 32'd9, "cycles_c10");
        wr(MMIO + 32'h1, 32'h1234);
        rd(MMIO + 32'h1, 32'd0, "cycles_clr");
        cycle();
        rd(MMIO + 32'h1, 32'd1, "cycles_after_clr");

        // RAM
        wr(32'd0, 32'h1111_0000);
        wr(32'd5, 32'hDEAD_BEEF);
        rd(32'd5, 32'hDEAD_BEEF, "ram_rd5");
        addr_i = 32'd5; wdata_i = 32'h1234_5678; we_i = 1'b1;
        #1;
        check("ram_rdw_old", rdata_o, 32'hDEAD_BEEF);
        cycle();
        we_i = 1'b0;
        rd(32'd5, 32'h1234_5678, "ram_rdw_new");
        rd(DEPTH, 32'h0, "unmapped_rd");
        wr(DEPTH, 32'hBAD0_BAD0);
        rd(32'd0, 32'h1111_0000, "unmapped_wr_alias");
        rd(MMIO + 32'h10, 32'h0, "io_other_off");

        // GPIO
        wr(MMIO, 32'h0000_00A5);
        check("gpio_out", gpio_o, 32'hA5);
        rd(MMIO, 32'hA5, "gpio_rd");
        rd(MMIO + 32'h2, 32'h0, "txdata_rd");

        // FIFO fill, overflow, clear, drain
        tx_ready_i = 1'b0;
        for (int i = 1; i <= 8; i++) wr(MMIO + 32'h2, 32'(i));
        rd(MMIO + 32'h3, 32'h82, "status_full");
        check("head_1", tx_data_o, 32'd1);
        wr(MMIO + 32'h2, 32'd9);
        rd(MMIO + 32'h3, 32'h86, "status_ovf");
        wr(MMIO + 32'h3, 32'h0000_0003);
        rd(MMIO + 32'h3, 32'h86, "ovf_no_clear");
        wr(MMIO + 32'h3, 32'h0000_0004);
        rd(MMIO + 32'h3, 32'h82, "ovf_clear");
        tx_ready_i = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) cycle();
        tx_ready_i = 1'b0;
        check("drain_done", 32'(sb_q.size()), 32'd0);
        rd(MMIO + 32'h3, 32'h1, "status_empty");

        // Full with concurrent pop and push
        for (int i = 0; i < 8; i++) wr(MMIO + 32'h2, 32'h100 + 32'(i));
        tx_ready_i = 1'b1;
        wr(MMIO + 32'h2, 32'h55);
        tx_ready_i = 1'b0;
        rd(MMIO + 32'h3, 32'h82, "full_pushpop");
        check("head_after_pop", tx_data_o, 32'h101);
        tx_ready_i = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) cycle();
        check("drain2_done", 32'(sb_q.size()), 32'd0);

        // Empty with push and ready
        wr(MMIO + 32'h2, 32'hAB);
        tx_ready_i = 1'b0;
        rd(MMIO + 32'h3, 32'h10, "empty_push_ready");
        check("empty_push_head", tx_data_o, 32'hAB);
        tx_ready_i = 1'b1;
        cycle();
        tx_ready_i = 1'b0;

        // Reset mid-drain
        for (int i = 0; i < 3; i++) wr(MMIO + 32'h2, 32'h200 + 32'(i));
        tx_ready_i = 1'b1;
        cycle();
        RST = 1'b1;
        addr_i = MMIO; wdata_i = 32'hFF; we_i = 1'b1;
        cycle();
        we_i = 1'b0;
        RST = 1'b0;
        tx_ready_i = 1'b0;
        check("rstmid_valid", {31'b0, tx_valid_o}, 32'h0);
        rd(MMIO + 32'h3, 32'h1, "rstmid_status");
        check("rst_gpio_ignored_wr", gpio_o, 32'h0);
        rd(32'd5, 32'h1234_5678, "ram_kept");
        rd(32'd0, 32'h1111_0000, "ram0_kept");

        // Counter wrap on the narrow instance
        addr2 = 12'hF01; we2 = 1'b1;
        step2();
        we2 = 1'b0;
        #1;
        check("wrap_clr", {20'b0, rdata2}, 32'h0);
        for (int i = 0; i < 4095; i++) step2();
        #1;
        check("wrap_max", {20'b0, rdata2}, 32'hFFF);
        step2();
        #1;
        check("wrap_zero", {20'b0, rdata2}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
